// File: rtl/jamma_pkg.sv
// Shared definitions for the JAMMA input front-end: scan states, joystick
// bit positions and the active-low idle value.
package jamma_pkg;

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } scan_state_t;

  localparam int JOY_W_DEFAULT = 8;

  localparam int BIT_UP    = 0;
  localparam int BIT_DOWN  = 1;
  localparam int BIT_LEFT  = 2;
  localparam int BIT_RIGHT = 3;
  localparam int BIT_FIRE1 = 4;
  localparam int BIT_FIRE2 = 5;
  localparam int BIT_START = 7;

  localparam logic [JOY_W_DEFAULT-1:0] JOY_IDLE = '1;

endpackage

// File: rtl/coin_pulse_stretch.sv
// One coin input: two-flop synchroniser, falling-edge detect, and a
// fixed-length active-low pulse that cannot be retriggered while running.
module coin_pulse_stretch #(
  parameter  int PULSE_CYCLES = 16,
  localparam int CNT_W        = $clog2(PULSE_CYCLES + 1)
) (
  input  logic pclk,
  input  logic reset,
  input  logic coin_n,
  output logic pulse_n
);

  logic             sync1;
  logic             sync2;
  logic             sync_prev;
  logic             active;
  logic [CNT_W-1:0] cnt;

  // sync_prev keeps the previous synchronised level so a 1->0 edge is seen once
  always_ff @(posedge pclk) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      active    <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1     <= coin_n;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (active) begin
        if (cnt == '0) active <= 1'b0;
        else           cnt    <= cnt - CNT_W'(1);
      end else if (sync_prev && !sync2) begin
        active <= 1'b1;
        cnt    <= CNT_W'(PULSE_CYCLES - 1);
      end
    end
  end

  assign pulse_n = ~active;

endmodule

// File: rtl/jamma_input_mux.sv
// Scans the shared JAMMA joystick bus one player at a time, merges it with the
// keyboard image, debounces each channel, and stretches coin edges.
module jamma_input_mux
  import jamma_pkg::*;
#(
  parameter  int NUM_PLAYERS       = 2,
  parameter  int JOY_W             = JOY_W_DEFAULT,
  parameter  int SETTLE_CYCLES     = 4,
  parameter  int DEBOUNCE_SCANS    = 3,
  parameter  int COIN_W            = 2,
  parameter  int COIN_PULSE_CYCLES = 16,
  parameter  int JOY_TYPE          = 1,
  localparam int SEL_W             = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                         pclk,
  input  logic                         reset,
  output logic [SEL_W-1:0]             jsel,
  input  logic [JOY_W-1:0]             jjoy,
  input  logic [COIN_W-1:0]            jcoin,
  input  logic [NUM_PLAYERS*JOY_W-1:0] kbd_joy,
  input  logic                         swap_players,
  output logic [NUM_PLAYERS*JOY_W-1:0] joy_out,
  output logic [COIN_W-1:0]            coin_out,
  output logic                         scan_done
);

  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_PLAYERS - 1);
  localparam logic [3:0]       DEB      = 4'(DEBOUNCE_SCANS);
  localparam logic [JOY_W-1:0] DIR_MASK = JOY_W'((1 << (BIT_FIRE2 + 1)) - 1);

  scan_state_t      state;
  scan_state_t      state_nxt;
  logic [SEL_W-1:0] ch;
  logic [7:0]       settle_cnt;
  logic             swap_q;
  logic             sample_en;
  logic [JOY_W-1:0] raw;
  logic [JOY_W-1:0] prev_q   [NUM_PLAYERS];
  logic [3:0]       stable_q [NUM_PLAYERS];
  logic [JOY_W-1:0] out_q    [NUM_PLAYERS];

  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= SELECT;
      ch         <= '0;
      settle_cnt <= '0;
      swap_q     <= 1'b0;
      scan_done  <= 1'b0;
    end else begin
      state  <= state_nxt;
      swap_q <= swap_players;
      if (state == SELECT) settle_cnt <= 8'(SETTLE_CYCLES - 1);
      else if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - 8'd1;
      if (state == SAMPLE) ch <= (ch == LAST_CH) ? '0 : ch + SEL_W'(1);
      scan_done <= (JOY_TYPE == 0) ? 1'b1 : (state == SAMPLE && ch == LAST_CH);
    end
  end

  // Without a JAMMA harness the scanner parks in SELECT with jsel at 0
  always_comb begin
    state_nxt = state;
    case (state)
      SELECT:  state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = SELECT;
      default: state_nxt = SELECT;
    endcase
    if (JOY_TYPE == 0) state_nxt = SELECT;
  end

  assign jsel      = ch;
  assign sample_en = (JOY_TYPE == 0) ? 1'b1 : (state == SAMPLE);

  // Keyboard-only boards still see the direction/fire pins, never start/coin lines
  always_comb begin
    raw = jjoy & kbd_joy[int'(ch)*JOY_W +: JOY_W];
    if (JOY_TYPE == 0) raw = (jjoy | ~DIR_MASK) & kbd_joy[JOY_W-1:0];
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        prev_q[i]   <= '1;
        stable_q[i] <= '0;
        out_q[i]    <= '1;
      end
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (JOY_TYPE == 0 && i != 0) begin
          out_q[i] <= kbd_joy[i*JOY_W +: JOY_W];
        end else if (sample_en && int'(ch) == i) begin
          if (raw == prev_q[i]) begin
            if (stable_q[i] != DEB) stable_q[i] <= stable_q[i] + 4'd1;
            if (stable_q[i] >= DEB - 4'd1) out_q[i] <= prev_q[i];
          end else begin
            prev_q[i]   <= raw;
            stable_q[i] <= 4'd1;
            if (DEB == 4'd1) out_q[i] <= raw;
          end
        end
      end
    end
  end

  if (NUM_PLAYERS >= 2) begin : g_swap
    always_comb begin
      for (int i = 0; i < NUM_PLAYERS; i++) joy_out[i*JOY_W +: JOY_W] = out_q[i];
      if (swap_q) begin
        joy_out[0 +: JOY_W]     = out_q[1];
        joy_out[JOY_W +: JOY_W] = out_q[0];
      end
    end
  end else begin : g_single
    assign joy_out = out_q[0];
  end

  for (genvar c = 0; c < COIN_W; c++) begin : g_coin
    coin_pulse_stretch #(
      .PULSE_CYCLES(COIN_PULSE_CYCLES)
    ) u_coin (
      .pclk   (pclk),
      .reset  (reset),
      .coin_n (jcoin[c]),
      .pulse_n(coin_out[c])
    );
  end

endmodule

// File: tb/tb_jamma_input_mux.sv
// Scoreboard bench: stimulus pushes cycle-tagged expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_jamma_input_mux;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [0:0]  jsel;
  logic [7:0]  jjoy;
  logic [1:0]  jcoin = 2'b11;
  logic [15:0] kbd_joy = 16'hFFFF;
  logic        swap_players = 1'b0;
  logic [15:0] joy_out;
  logic [1:0]  coin_out;
  logic        scan_done;

  logic [7:0]  ch0_val = 8'hFF;
  logic [7:0]  ch1_val = 8'hFF;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  localparam logic [3:0] M_JOY = 4'b0001;
  localparam logic [3:0] M_COIN = 4'b0010;
  localparam logic [3:0] M_SEL = 4'b0100;
  localparam logic [3:0] M_SD = 4'b1000;
  localparam logic [3:0] M_ALL = 4'b1111;

  typedef struct {
    int          cyc;
    logic [3:0]  mask;
    logic [15:0] joy;
    logic [1:0]  coin;
    logic        sel;
    logic        sd;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_nm;

  // The board drives the bus according to the select line it is given
  assign jjoy = (jsel == 1'b1) ? ch1_val : ch0_val;

  jamma_input_mux dut (
    .pclk        (pclk),
    .reset       (reset),
    .jsel        (jsel),
    .jjoy        (jjoy),
    .jcoin       (jcoin),
    .kbd_joy     (kbd_joy),
    .swap_players(swap_players),
    .joy_out     (joy_out),
    .coin_out    (coin_out),
    .scan_done   (scan_done)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic expectAt(input int c, input string nm, input logic [3:0] m,
                          input logic [15:0] j, input logic [1:0] co,
                          input logic s, input logic d);
    exp_t e;
    e.cyc = c; e.mask = m; e.joy = j; e.coin = co; e.sel = s; e.sd = d;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic checkOutput(input string nm, input int c,
                             input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  task automatic applyStimulus(input int c);
    while (cyc < c) @(negedge pclk);
  endtask

  // Monitor: compare every expectation due at this cycle
  always @(negedge pclk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      if (mon_e.cyc < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s missed: due cycle %0d seen at %0d", mon_nm, mon_e.cyc, cyc);
      end else begin
        if (mon_e.mask[0]) checkOutput({mon_nm, ".joy_out"}, cyc, joy_out, mon_e.joy);
        if (mon_e.mask[1]) checkOutput({mon_nm, ".coin_out"}, cyc, {14'd0, coin_out}, {14'd0, mon_e.coin});
        if (mon_e.mask[2]) checkOutput({mon_nm, ".jsel"}, cyc, {15'd0, jsel}, {15'd0, mon_e.sel});
        if (mon_e.mask[3]) checkOutput({mon_nm, ".scan_done"}, cyc, {15'd0, scan_done}, {15'd0, mon_e.sd});
      end
    end
  end

  initial begin
    // Reset held through posedge 3; samples then land on edges 3+6m, ch0 for odd m
    expectAt(3,  "reset_state",      M_ALL,         16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(4,  "select_hold",      M_SEL,         16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(9,  "jsel_ch1",         M_SEL | M_SD,  16'hFFFF, 2'b11, 1'b1, 1'b0);
    expectAt(14, "no_early_done",    M_SD,          16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(15, "scan_wrap",        M_JOY | M_SEL | M_SD, 16'hFFFF, 2'b11, 1'b0, 1'b1);
    expectAt(16, "done_one_cycle",   M_SD,          16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(21, "jsel_ch1_again",   M_SEL,         16'hFFFF, 2'b11, 1'b1, 1'b0);
    expectAt(27, "scan_period",      M_SEL | M_SD,  16'hFFFF, 2'b11, 1'b0, 1'b1);
    applyStimulus(3);
    reset = 1'b0;

    // Player 2 presses UP; channel 1 samples at edges 39, 51, 63
    applyStimulus(28);
    expectAt(51, "debounce_2_of_3",  M_JOY,         16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(62, "debounce_pending", M_JOY,         16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(63, "debounce_ch1",     M_JOY,         16'hFEFF, 2'b11, 1'b0, 1'b0);
    ch1_val = 8'hFE;

    // Single-sample glitch on channel 0 at edge 69
    applyStimulus(64);
    expectAt(70,  "glitch_next",     M_JOY,         16'hFEFF, 2'b11, 1'b0, 1'b0);
    expectAt(82,  "glitch_recover",  M_JOY,         16'hFEFF, 2'b11, 1'b0, 1'b0);
    expectAt(106, "glitch_settled",  M_JOY,         16'hFEFF, 2'b11, 1'b0, 1'b0);
    applyStimulus(68);
    ch0_val = 8'h7F;
    applyStimulus(69);
    ch0_val = 8'hFF;

    // Coin 0: falls after edge 120, pulse low over cycles 123..138
    applyStimulus(110);
    expectAt(122, "coin_sync_delay", M_COIN,        16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(123, "coin_start",      M_COIN | M_JOY, 16'hFEFF, 2'b10, 1'b0, 1'b0);
    expectAt(130, "coin_no_retrig",  M_COIN,        16'hFFFF, 2'b10, 1'b0, 1'b0);
    expectAt(138, "coin_last_low",   M_COIN,        16'hFFFF, 2'b10, 1'b0, 1'b0);
    expectAt(139, "coin_end",        M_COIN,        16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(145, "coin_no_extend",  M_COIN,        16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(180, "coin_held_once",  M_COIN,        16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(225, "coin_release",    M_COIN,        16'hFFFF, 2'b11, 1'b0, 1'b0);
    applyStimulus(120);
    jcoin[0] = 1'b0;
    applyStimulus(127);
    jcoin[0] = 1'b1;
    applyStimulus(128);
    jcoin[0] = 1'b0;
    applyStimulus(220);
    jcoin[0] = 1'b1;

    // Coin 1 pulse running, reset lands while the scanner is in SETTLE (ch1)
    applyStimulus(221);
    expectAt(250, "pre_reset",       M_COIN | M_SEL | M_JOY, 16'hFEFF, 2'b01, 1'b1, 1'b0);
    expectAt(251, "reset_mid_scan",  M_ALL,         16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(256, "no_partial_pulse", M_COIN,       16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(259, "rescan_jsel",     M_SEL,         16'hFFFF, 2'b11, 1'b1, 1'b0);
    expectAt(271, "kbd_debounce_2",  M_JOY,         16'hFFFF, 2'b11, 1'b0, 1'b0);
    expectAt(283, "kbd_debounce_3",  M_JOY,         16'hFFEF, 2'b11, 1'b0, 1'b0);
    expectAt(288, "pre_swap",        M_JOY,         16'hFFEF, 2'b11, 1'b0, 1'b0);
    expectAt(289, "swap",            M_JOY | M_COIN, 16'hEFFF, 2'b11, 1'b0, 1'b0);
    applyStimulus(240);
    jcoin[1] = 1'b0;
    applyStimulus(243);
    jcoin[1] = 1'b1;
    applyStimulus(250);
    reset = 1'b1;
    applyStimulus(253);
    reset = 1'b0;
    ch1_val = 8'hFF;
    kbd_joy[7:0] = 8'hEF;

    applyStimulus(288);
    swap_players = 1'b1;

    while (exp_q.size() > 0 && cyc < 400) @(negedge pclk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
